instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit that drives the synchronous 256-entry instruction memory and hands 8-bit instructions to the decoder. It owns the program counter, absorbs the memory's one-cycle registered read latency, stalls cleanly on decoder backpressure (valid/ready), and accepts PC redirects for branches and jumps. It sits between the instruction memory (address out, data in) and the decode stage.

## Interface
- RESET_PC, default 8'h00: PC value loaded by reset.
- clock  input  1  rising-edge clock shared with the instruction memory.
- reset  input  1  synchronous, active-high reset.
- pccounter  output  8  address driven to the instruction memory; sampled by the memory on every rising edge.
- saidaInstrucao  input  8  memory read data; it holds mem[pccounter as sampled at the previous edge].
- instr_out  output  8  instruction presented to the decoder.
- instr_pc  output  8  address that `instr_out` was fetched from.
- instr_valid  output  1  `instr_out` and `instr_pc` are valid.
- instr_ready  input  1  decoder accepts the instruction; a transfer happens on an edge where `instr_valid && instr_ready`.
- redirect_valid  input  1  one-cycle request to restart fetch at `redirect_pc`.
- redirect_pc  input  8  new fetch address.
- halt_req  input  1  one-cycle request to stop fetching.
- halted  output  1  high while in state HALTED.

## Operation
- States: IDLE, FETCH, HALTED.
  - IDLE lasts one cycle after reset and always goes to FETCH.
  - FETCH goes to HALTED on `halt_req`, or on wrap (see Configuration).
  - HALTED goes to FETCH only on `redirect_valid`.
- Internal state: `pend_valid` and `pend_pc` track the single read in flight.
- Per-edge terms, evaluated in this order:
  - `accept` = `pend_valid && !redirect_valid && (!instr_valid || instr_ready)`. On accept, `instr_out` <= `saidaInstrucao`, `instr_pc` <= `pend_pc`, `instr_valid` <= 1.
  - If there is no accept but `instr_valid && instr_ready`, then `instr_valid` <= 0.
  - `issue` = `state==FETCH && !redirect_valid && !halt_req && (!pend_valid || accept)`. On issue, `pend_pc` <= `pccounter`, `pccounter` <= `pccounter + 1` (mod 256), `pend_valid` <= 1.
  - `replay` = `pend_valid && !accept && !redirect_valid`. On replay, `pccounter` <= `pend_pc` and `pend_valid` <= 0. The stalled address is re-read and no instruction is lost or duplicated.
  - If none of the above applies, `pend_valid` <= 0.
- Redirect has the highest priority. It sets `pccounter` <= `redirect_pc`, clears `pend_valid` and `instr_valid` (younger instructions are flushed), and sets state to FETCH.
- `halt_req` suppresses the issue in the same cycle. A pending read still drains to the output in HALTED. If `halt_req` and `redirect_valid` arrive together, redirect wins.
- While `instr_valid && !instr_ready`, `instr_out` and `instr_pc` are held stable.

## Timing
- Reset values: `pccounter`=RESET_PC, `instr_out`=8'h00, `instr_pc`=8'h00, `instr_valid`=0, `halted`=0, state=IDLE, `pend_valid`=0.
- Reset mid-operation discards all in-flight state within one edge.
- Latency: `pccounter`=A at edge n, then `saidaInstrucao`=mem[A] after edge n+1, then `instr_valid` with A after edge n+2. First `instr_valid` appears 3 edges after reset deasserts.
- Throughput: one instruction per cycle while `instr_ready`=1.
- After a redirect edge, the first instruction from `redirect_pc` is valid 2 edges later.
- Stall cost: one lost fetch cycle (the replay) per stall episode.
- `halted` is registered and asserts the edge after `halt_req` or a wrap.

## Configuration
- IFETCH_WRAP_HALT_EN defined: issuing from `pccounter`=8'hFF moves the state to HALTED. `pccounter` becomes 8'h00, the FF instruction still drains to the output, and nothing further is issued until a redirect.
- IFETCH_WRAP_HALT_EN undefined: the PC wraps 8'hFF -> 8'h00 and fetch continues; `halted` asserts only via `halt_req`.

## Test plan
- Reset, then `instr_ready`=1, with memory [1]=0x27, [2]=0x02, [3]=0xC8 -> outputs (pc, instr) are (0,0x00), (1,0x27), (2,0x02), (3,0xC8) on consecutive cycles; the first `instr_valid` is at edge 3.
- Hold `instr_ready`=0 for 5 cycles while (2,0x02) is presented -> output stays (2,0x02). After release, (3,0xC8), (4,…) follow with no skip or duplicate.
- `redirect_valid` with `redirect_pc`=8'h09 while (3,0xC8) is pending -> `instr_valid` drops the next cycle; (9,mem[9]) is valid 2 edges after the redirect; 0xC8 never appears.
- `halt_req` at PC=5 -> `halted`=1 the next edge, at most one trailing instruction is delivered, then `instr_valid`=0 and `pccounter` is frozen; a redirect to 0x01 resumes with (1,0x27).
- Redirect to 0xFE and run: with IFETCH_WRAP_HALT_EN -> (0xFE), (0xFF) are delivered, then `halted`=1. Without it -> (0xFE), (0xFF), (0x00), (0x01) are delivered.
- Assert `reset` while stalled with `pend_valid`=1 -> next cycle all outputs equal their reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle.
// master = fetch unit, slave = memory/decoder/control side.
interface instruction_fetch_if;
    logic [7:0] pccounter;
    logic [7:0] saidaInstrucao;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halt_req;
    logic       halted;

    modport master (
        output pccounter,
        output instr_out,
        output instr_pc,
        output instr_valid,
        output halted,
        input  saidaInstrucao,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req
    );

    modport slave (
        input  pccounter,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        input  halted,
        output saidaInstrucao,
        output instr_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC owner feeding a 1-cycle-latency instruction memory to the decoder.
// Optional IFETCH_WRAP_HALT_EN: halt after issuing from PC 8'hFF.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic          clock,
    input logic          reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pc_q;
    logic [7:0] pend_pc_q;
    logic       pend_valid_q;
    logic [7:0] out_q;
    logic [7:0] out_pc_q;
    logic       out_valid_q;
    logic       halted_c;

    logic accept;
    logic issue;
    logic replay;
    logic wrap;

    assign accept = pend_valid_q && !bus.redirect_valid
                 && (!out_valid_q || bus.instr_ready);

    assign issue = (state_q == FETCH) && !bus.redirect_valid
                && !bus.halt_req && (!pend_valid_q || accept);

    assign replay = pend_valid_q && !accept && !bus.redirect_valid;

`ifdef IFETCH_WRAP_HALT_EN
    assign wrap = issue && (pc_q == 8'hFF);
`else
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (bus.halt_req || wrap) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_valid) state_d = FETCH;
    end

    always_comb begin
        halted_c = (state_q == HALTED);
    end

    // Datapath: redirect flushes everything younger than the new PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            pend_pc_q    <= 8'h00;
            pend_valid_q <= 1'b0;
            out_q        <= 8'h00;
            out_pc_q     <= 8'h00;
            out_valid_q  <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q         <= bus.redirect_pc;
            pend_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                out_q       <= bus.saidaInstrucao;
                out_pc_q    <= pend_pc_q;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.instr_ready) begin
                out_valid_q <= 1'b0;
            end
            // A stalled read is dropped and re-issued from pend_pc.
            if (issue) begin
                pend_pc_q    <= pc_q;
                pc_q         <= pc_q + 8'd1;
                pend_valid_q <= 1'b1;
            end else if (replay) begin
                pc_q         <= pend_pc_q;
                pend_valid_q <= 1'b0;
            end else begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pccounter   = pc_q;
    assign bus.instr_out   = out_q;
    assign bus.instr_pc    = out_pc_q;
    assign bus.instr_valid = out_valid_q;
    assign bus.halted      = halted_c;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: memory model, scoreboard of expected fetch PCs.
// Build with +define+IFETCH_WRAP_HALT_EN to check the wrap-halt variant.
module tb_instruction_fetch;
    logic clock;
    logic reset;
    logic [7:0] mem [256];
    logic [7:0] q [$];
    int checks;
    int errors;

    instruction_fetch_if ifc ();

    instruction_fetch #(.RESET_PC(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) ifc.saidaInstrucao <= mem[ifc.pccounter];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfer at the coming edge: inputs are stable between negedge and posedge.
    always @(negedge clock) begin
        if (!reset && ifc.instr_valid && ifc.instr_ready) begin
            logic [7:0] e;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected: observed pc %0h expected none",
                       ifc.instr_pc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("xfer_pc", ifc.instr_pc, e);
                chk("xfer_instr", ifc.instr_out, mem[e]);
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (q.size() != 0 && n < budget);
        chk("drain", q.size(), 0);
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        ifc.instr_ready    = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = pc;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("redir_valid", ifc.instr_valid, 0);
        chk("redir_pc", ifc.pccounter, pc);
        chk("redir_halted", ifc.halted, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h00;
        mem[1] = 8'h27;
        mem[2] = 8'h02;
        mem[3] = 8'hC8;
        reset = 1'b1;
        ifc.instr_ready    = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 8'h00;
        ifc.halt_req       = 1'b0;
        tick();
        tick();
        chk("rst_pc", ifc.pccounter, 8'h00);
        chk("rst_out", ifc.instr_out, 8'h00);
        chk("rst_ipc", ifc.instr_pc, 8'h00);
        chk("rst_valid", ifc.instr_valid, 0);
        chk("rst_halted", ifc.halted, 0);

        // Startup latency and streaming
        q.push_back(8'h00);
        q.push_back(8'h01);
        q.push_back(8'h02);
        reset = 1'b0;
        tick();
        chk("e1_valid", ifc.instr_valid, 0);
        tick();
        chk("e2_valid", ifc.instr_valid, 0);
        tick();
        chk("e3_valid", ifc.instr_valid, 1);
        chk("e3_pc", ifc.instr_pc, 8'h00);
        tick();
        chk("e4_pc", ifc.instr_pc, 8'h01);
        chk("e4_instr", ifc.instr_out, 8'h27);
        tick();
        chk("e5_pc", ifc.instr_pc, 8'h02);

        // Backpressure: output held, then resumes without skip
        ifc.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", ifc.instr_valid, 1);
            chk("stall_pc", ifc.instr_pc, 8'h02);
            chk("stall_instr", ifc.instr_out, 8'h02);
        end
        q.push_back(8'h03);
        q.push_back(8'h04);
        ifc.instr_ready = 1'b1;
        drain(20);
        ifc.instr_ready = 1'b0;

        // Redirect flushes presented/pending instructions
        redirect_to(8'h09);
        q.push_back(8'h09);
        q.push_back(8'h0A);
        ifc.instr_ready = 1'b1;
        tick();
        chk("rd1_valid", ifc.instr_valid, 0);
        tick();
        chk("rd2_valid", ifc.instr_valid, 1);
        chk("rd2_pc", ifc.instr_pc, 8'h09);
        drain(20);
        ifc.instr_ready = 1'b0;

        // Halt at PC=5
        redirect_to(8'h04);
        q.push_back(8'h04);
        ifc.instr_ready = 1'b1;
        tick();
        chk("h_pc", ifc.pccounter, 8'h05);
        ifc.halt_req = 1'b1;
        tick();
        ifc.halt_req = 1'b0;
        chk("h_halted", ifc.halted, 1);
        chk("h_trail", ifc.instr_pc, 8'h04);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("h_valid", ifc.instr_valid, 0);
            chk("h_frozen", ifc.pccounter, 8'h05);
            chk("h_still", ifc.halted, 1);
        end
        chk("h_q", q.size(), 0);
        redirect_to(8'h01);
        q.push_back(8'h01);
        ifc.instr_ready = 1'b1;
        tick();
        tick();
        chk("res_pc", ifc.instr_pc, 8'h01);
        chk("res_instr", ifc.instr_out, 8'h27);
        drain(20);
        ifc.instr_ready = 1'b0;

        // PC wrap
        redirect_to(8'hFE);
        q.push_back(8'hFE);
        q.push_back(8'hFF);
`ifndef IFETCH_WRAP_HALT_EN
        q.push_back(8'h00);
        q.push_back(8'h01);
`endif
        ifc.instr_ready = 1'b1;
        drain(20);
`ifdef IFETCH_WRAP_HALT_EN
        chk("wrap_halted", ifc.halted, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_valid", ifc.instr_valid, 0);
            chk("wrap_pc", ifc.pccounter, 8'h00);
        end
`else
        chk("wrap_run", ifc.halted, 0);
`endif
        ifc.instr_ready = 1'b0;

        // Reset while stalled with a read in flight
        redirect_to(8'h20);
        tick();
        tick();
        chk("pre_valid", ifc.instr_valid, 1);
        chk("pre_pc", ifc.instr_pc, 8'h20);
        reset = 1'b1;
        tick();
        chk("r2_pc", ifc.pccounter, 8'h00);
        chk("r2_out", ifc.instr_out, 8'h00);
        chk("r2_ipc", ifc.instr_pc, 8'h00);
        chk("r2_valid", ifc.instr_valid, 0);
        chk("r2_halted", ifc.halted, 0);
        reset = 1'b0;
        q.push_back(8'h00);
        q.push_back(8'h01);
        ifc.instr_ready = 1'b1;
        tick();
        tick();
        chk("r2_e2", ifc.instr_valid, 0);
        tick();
        chk("r2_e3", ifc.instr_valid, 1);
        chk("r2_first", ifc.instr_pc, 8'h00);
        drain(20);
        ifc.instr_ready = 1'b0;
        tick();
        tick();
        chk("end_q", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
